aes_ctr_stream: RTL

AES_CTR_STREAM -- requirements
Module: aes_ctr_stream

---
 rtl/aes_ctr_stream.sv | 137 +++++++++++++
 1 files changed

// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: AES-CTR keystream/data pairing stage.
//
// Each accepted plaintext block issues one keystream request to the cipher
// core in the same cycle, using the counter value presented with the block.
// Plaintext is parked in a 16-entry data FIFO. Keystream returns in request
// order into a 16-entry keystream FIFO. The head entries of the two FIFOs are
// XORed to form the output block.
//
// Optional feature macro: AES_STREAM_RSP_CHECK_EN
//   When defined, adds a sticky 'err' output that flags keystream responses
//   arriving with no request outstanding.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   ctr               counter value for the block being offered
//   in_valid/ready    plaintext handshake, in_block data
//   out_valid/ready   result handshake, out_block = data ^ keystream
//   fifo_empty        nothing accepted and not yet output
//   pending_blks      blocks accepted but not yet output (0..16)
//   ks_req_*          keystream request to the cipher core
//   ks_rsp_*          keystream response (in order, no backpressure)
//   err               sticky spurious-response flag (macro only)

module aes_ctr_stream (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] ctr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         fifo_empty,
  output logic [4:0]   pending_blks,
  output logic         ks_req_valid,
  input  logic         ks_req_ready,
  output logic [127:0] ks_req_ctr,
  input  logic         ks_rsp_valid,
  input  logic [127:0] ks_rsp_block
`ifdef AES_STREAM_RSP_CHECK_EN
  ,
  output logic         err
`endif
);

  localparam int DEPTH = 16;

  logic [4:0]   pend_q, pend_d;
  logic [4:0]   outst_q, outst_d;
  logic [3:0]   dwr_q, drd_q, kwr_q, krd_q;
  logic [127:0] dmem_q [DEPTH];
  logic [127:0] kmem_q [DEPTH];
  logic [4:0]   ks_cnt;
  logic         full;
  logic         in_hs, out_hs, rsp_acc;

  assign full         = (pend_q == 5'd16);
  assign in_ready     = !full && ks_req_ready;
  assign ks_req_valid = in_valid && !full;
  assign ks_req_ctr   = ctr;

  // The request handshake is identical to the input handshake, so one
  // signal drives both the data push and the outstanding-count increment.
  assign in_hs   = in_valid && in_ready;
  // Responses with nothing outstanding belong to pre-reset requests or are
  // spurious; they never enter the keystream FIFO.
  assign rsp_acc = ks_rsp_valid && (outst_q != 5'd0);

  // Keystream entries held = accepted blocks minus those still awaiting
  // keystream; this avoids separate occupancy tracking for the 4-bit pointers.
  assign ks_cnt    = pend_q - outst_q;
  assign out_valid = (pend_q != 5'd0) && (ks_cnt != 5'd0);
  assign out_hs    = out_valid && out_ready;

  // Head entries are never overwritten while occupied, so this stays stable
  // across a stall.
  assign out_block    = dmem_q[drd_q] ^ kmem_q[krd_q];
  assign pending_blks = pend_q;
  assign fifo_empty   = (pend_q == 5'd0);

  always_comb begin
    pend_d = pend_q;
    case ({in_hs, out_hs})
      2'b10:   pend_d = pend_q + 5'd1;
      2'b01:   pend_d = pend_q - 5'd1;
      default: pend_d = pend_q;
    endcase
  end

  always_comb begin
    outst_d = outst_q;
    case ({in_hs, rsp_acc})
      2'b10:   outst_d = outst_q + 5'd1;
      2'b01:   outst_d = outst_q - 5'd1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= 5'd0;
      outst_q <= 5'd0;
      dwr_q   <= 4'd0;
      drd_q   <= 4'd0;
      kwr_q   <= 4'd0;
      krd_q   <= 4'd0;
    end else begin
      pend_q  <= pend_d;
      outst_q <= outst_d;
      if (in_hs)   dwr_q <= dwr_q + 4'd1;
      if (rsp_acc) kwr_q <= kwr_q + 4'd1;
      if (out_hs) begin
        drd_q <= drd_q + 4'd1;
        krd_q <= krd_q + 4'd1;
      end
    end
  end

  // Storage is not reset; validity is tracked entirely by the counters.
  always_ff @(posedge clk) begin
    if (in_hs)   dmem_q[dwr_q] <= in_block;
    if (rsp_acc) kmem_q[kwr_q] <= ks_rsp_block;
  end

`ifdef AES_STREAM_RSP_CHECK_EN
  logic err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                 err_q <= 1'b0;
    else if (ks_rsp_valid && outst_q == 5'd0) err_q <= 1'b1;
  end

  assign err = err_q;
`endif

endmodule
